// File: rtl/button_event_gen.sv
// button_event_gen: synchronise, debounce and classify three push buttons into one-hot single-cycle event pulses
module button_event_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_inc,
  input  logic btn_set,
  input  logic btn_sw,
  output logic inc_short,
  output logic inc_long,
  output logic set,
  output logic sw
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = LONG_CYCLES > 1 ? $clog2(LONG_CYCLES) : 1;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] HELD      = 2'd1;
  localparam logic [1:0] LONG_WAIT = 2'd2;

  // bit 0 = INC, bit 1 = SET, bit 2 = SW
  logic [2:0]    btn, s1_q, s_q, db_q, dbp_q, rise;
  logic [DW-1:0] cnt_q [3];
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          req_short, req_long;
  logic [3:0]    p_q, p_d, req, grant, out_q;

  assign btn  = {btn_sw, btn_set, btn_inc};
  assign rise = db_q & ~dbp_q;

  // two-flop synchroniser, per-button debounce counters and accepted-level history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s_q   <= '0;
      db_q  <= '0;
      dbp_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      s1_q  <= btn;
      s_q   <= s1_q;
      dbp_q <= db_q;
      for (int b = 0; b < 3; b++) begin
        if (s_q[b] == db_q[b]) cnt_q[b] <= '0;
        else if (cnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_q[b]  <= s_q[b];
          cnt_q[b] <= '0;
        end else cnt_q[b] <= cnt_q[b] + 1'b1;
      end
    end
  end

  // INC hold classifier: a release while still HELD is short, reaching the threshold is long (once per press)
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    req_short = 1'b0;
    req_long  = 1'b0;
    case (state_q)
      IDLE: if (rise[0]) begin
        state_d = HELD;
        hold_d  = '0;
      end
      HELD: if (!db_q[0]) begin
        req_short = 1'b1;
        state_d   = IDLE;
      end else if (hold_q == HW'(LONG_CYCLES - 1)) begin
        req_long = 1'b1;
        state_d  = LONG_WAIT;
      end else hold_d = hold_q + 1'b1;
      LONG_WAIT: state_d = db_q[0] ? LONG_WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // fixed-priority grant set > sw > long > short; a request for the bit being granted keeps it pending
  always_comb begin
    req      = {rise[1], rise[2], req_long, req_short};
    grant[3] = p_q[3];
    grant[2] = p_q[2] & ~p_q[3];
    grant[1] = p_q[1] & ~|p_q[3:2];
    grant[0] = p_q[0] & ~|p_q[3:1];
    p_d      = (p_q & ~grant) | req;
  end

  // FSM, pending bits and registered one-hot outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      p_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      p_q     <= p_d;
      out_q   <= grant;
    end
  end

  assign {set, sw, inc_long, inc_short} = out_q;
endmodule
